half_add_arbiter: RTL and testbench
===================================

// Module: half_add_arbiter
// PURPOSE
//  Shares one multi-cycle half-precision adder (enable/in1/in2/out, no done flag) among NUM_REQ clients.
//  Picks one requester round-robin, holds its operands stable and pulses the adder enable.
//  Waits a fixed ADD_LAT cycles, captures the sum and returns it to the owner with a valid/ready handshake.
//  Sits between the FP front-end clients and the single shared adder instance.
// PARAMETERS
//  NUM_REQ  4  number of requesters, 2..8
//  ADD_LAT  4  cycles from the adder enable pulse to a valid adder out, >=1
// PORTS
//  clk        in   1           clock
//  nrst       in   1           reset, asynchronous, active-low
//  req_valid  in   NUM_REQ     per-client request valid
//  req_a      in   NUM_REQ*16  per-client operand a, packed, client i at [16*i+:16]
//  req_b      in   NUM_REQ*16  per-client operand b, same packing
//  req_ready  out  NUM_REQ     one-hot accept; request i accepted when req_valid[i]&req_ready[i]
//  resp_valid out  NUM_REQ     one-hot result valid to owner
//  resp_sum   out  16          result (half), shared bus, meaningful only with resp_valid
//  resp_ready in   NUM_REQ     per-client result accept
//  add_en     out  1           adder enable, one-cycle pulse
//  add_in1    out  16          adder operand 1, held stable from ISSUE until next accept
//  add_in2    out  16          adder operand 2, same
//  add_out    in   16          adder result
//  busy       out  1           high whenever state != IDLE
// BEHAVIOUR
//  Reset values: state=IDLE, rr_ptr=0, all outputs 0, operand/result regs 0.
//  FSM IDLE->ISSUE->WAIT->RESP->IDLE.
//   IDLE:  grant = first valid client at or after rr_ptr, wrapping mod NUM_REQ.
//          req_ready[grant]=1 combinationally this cycle; operands latched; owner<=grant; ->ISSUE.
//          No valid client: stay IDLE, req_ready=0.
//   ISSUE: add_en=1 for exactly this cycle; cnt<=ADD_LAT-1; ->WAIT.
//   WAIT:  cnt decrements each cycle. At cnt==0, capture add_out into result reg; ->RESP.
//   RESP:  resp_valid[owner]=1, resp_sum=result reg.
//          On resp_ready[owner]: ->IDLE, rr_ptr<=(owner+1) mod NUM_REQ.
//          Else hold; back-pressure is unbounded.
//  Latency from accept cycle to resp_valid: ADD_LAT+2 cycles. Min period per op: ADD_LAT+3 cycles.
//  req_ready is 0 in every state except IDLE; at most one bit set ever.
//  A client may drop req_valid before it is granted (withdrawal, no effect).
//  Once accepted, the op always completes.
//  Simultaneous requests: only the winner is acked; the others must hold valid.
//  Fairness: each waiting client is served within NUM_REQ grants.
//  rr_ptr wrap: owner NUM_REQ-1 -> rr_ptr 0.
//  resp_ready from a non-owner is ignored.
//  add_in1/add_in2 never change while the adder is operating; they change only on accept.
//  Reset mid-operation: op dropped, no response, add_en low immediately.
//  No arithmetic on operands; the adder owns all rounding/special cases.
// CONFIGURATION
//  Macro HALF_ADD_ARB_ZERO_BYPASS_EN:
//   Defined: in IDLE on accept, if a==16'h0000 the result is b; if b==16'h0000 the result is a.
//     The FSM goes IDLE->RESP directly with no add_en pulse; response valid 1 cycle after accept.
//     Operand regs and add_in* are not updated.
//   Undefined: every op, including zero operands, takes the full adder path.
// STRUCTURE
//  Shared package half_pkg: half struct typedef {sign, expo[4:0], mant[9:0]}, HALF_W=16, HALF_ZERO=16'h0000.
//  Same package also holds the arb state enum {IDLE, ISSUE, WAIT, RESP}.
//  Sub-module rr_arbiter (NUM_REQ param): inputs req vector + ptr, outputs one-hot grant and index. Pure combinational.
//  Top holds the FSM, latency counter, owner/rr_ptr, operand and result regs.
// TESTING  (bench models adder: out=f(in1,in2) valid ADD_LAT cycles after add_en; 1.0=3C00, 2.0=4000, 3.0=4200)
//  1. Single client 0: a=3C00, b=4000 -> add_en once, resp_valid[0] 6 cycles after accept (ADD_LAT=4), resp_sum=4200.
//  2. All 4 valid continuously, resp_ready=1 -> grants in order 0,1,2,3,0; one op per 7 cycles; never two req_ready.
//  3. Owner 2 holds resp_ready=0 for 10 cycles -> resp_valid/resp_sum stable, req_ready all 0, no add_en.
//  4. Client 3 served, then clients 0 and 3 request -> rr_ptr wraps to 0, client 0 granted first.
//  5. nrst low during WAIT -> outputs 0 next cycle, no resp; post-reset request from client 1 completes normally.
//  6. ZERO_BYPASS_EN defined, a=0000, b=3C00 -> no add_en, resp_sum=3C00 one cycle after accept; undefined -> full path.

Source files
------------

// File: rtl/half_add_arbiter_pkg.sv
// Shared half-precision types and arbiter FSM state encoding.
package half_pkg;

    localparam int unsigned HALF_W    = 16;
    localparam logic [15:0] HALF_ZERO = 16'h0000;

    typedef struct packed {
        logic       sign;
        logic [4:0] expo;
        logic [9:0] mant;
    } half_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } arb_state_e;

    // Exact +0 only; -0 (16'h8000) still goes to the adder.
    function automatic logic is_zero(input half_t h);
        return h == HALF_ZERO;
    endfunction

endpackage

// File: rtl/half_add_arbiter_if.sv
// Client request/response and shared-adder signals for half_add_arbiter.
interface half_add_arbiter_if
    import half_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4
);

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*HALF_W-1:0] req_a;
    logic [NUM_REQ*HALF_W-1:0] req_b;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ-1:0]        resp_valid;
    logic [HALF_W-1:0]         resp_sum;
    logic [NUM_REQ-1:0]        resp_ready;
    logic                      add_en;
    logic [HALF_W-1:0]         add_in1;
    logic [HALF_W-1:0]         add_in2;
    logic [HALF_W-1:0]         add_out;
    logic                      busy;

    // Clients plus the shared adder.
    modport master (
        output req_valid, req_a, req_b, resp_ready, add_out,
        input  req_ready, resp_valid, resp_sum, add_en, add_in1, add_in2, busy
    );

    // The arbiter.
    modport slave (
        input  req_valid, req_a, req_b, resp_ready, add_out,
        output req_ready, resp_valid, resp_sum, add_en, add_in1, add_in2, busy
    );

endinterface

// File: rtl/half_add_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module rr_arbiter #(
    parameter  int unsigned NUM_REQ = 4,
    localparam int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   idx
);

    logic        found;
    int unsigned j;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            j = (32'(ptr) + i) % NUM_REQ;
            if (!found && req[j]) begin
                found    = 1'b1;
                grant[j] = 1'b1;
                idx      = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/half_add_arbiter.sv
// Round-robin sharing of one fixed-latency half adder among NUM_REQ clients.
// Optional macro HALF_ADD_ARB_ZERO_BYPASS_EN: zero operands skip the adder.
module half_add_arbiter
    import half_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ADD_LAT = 4
) (
    input logic               clk,
    input logic               nrst,
    half_add_arbiter_if.slave bus
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);
    localparam int unsigned CNT_W = $clog2(ADD_LAT + 1);

    arb_state_e         state_q, state_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    half_t              op_a_q, op_a_d;
    half_t              op_b_q, op_b_d;
    half_t              result_q, result_d;

    logic [NUM_REQ-1:0] grant;
    logic [IDX_W-1:0]   grant_idx;
    half_t              sel_a, sel_b;
    logic [NUM_REQ-1:0] req_ready;
    logic [NUM_REQ-1:0] resp_valid;
    logic               add_en;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req   (bus.req_valid),
        .ptr   (rr_ptr_q),
        .grant (grant),
        .idx   (grant_idx)
    );

    assign sel_a = bus.req_a[32'(grant_idx)*HALF_W +: HALF_W];
    assign sel_b = bus.req_b[32'(grant_idx)*HALF_W +: HALF_W];

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        owner_d    = owner_q;
        cnt_d      = cnt_q;
        op_a_d     = op_a_q;
        op_b_d     = op_b_q;
        result_d   = result_q;
        req_ready  = '0;
        resp_valid = '0;
        add_en     = 1'b0;

        case (state_q)
            IDLE: begin
                if (|grant) begin
                    req_ready = grant;
                    owner_d   = grant_idx;
`ifdef HALF_ADD_ARB_ZERO_BYPASS_EN
                    if (is_zero(sel_a)) begin
                        result_d = sel_b;
                        state_d  = RESP;
                    end else if (is_zero(sel_b)) begin
                        result_d = sel_a;
                        state_d  = RESP;
                    end else
`endif
                    begin
                        op_a_d  = sel_a;
                        op_b_d  = sel_b;
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                add_en  = 1'b1;
                cnt_d   = CNT_W'(ADD_LAT - 1);
                state_d = WAIT;
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    result_d = bus.add_out;
                    state_d  = RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                resp_valid[owner_q] = 1'b1;
                if (bus.resp_ready[owner_q]) begin
                    state_d  = IDLE;
                    rr_ptr_d = (32'(owner_q) == NUM_REQ - 1) ? '0 : owner_q + IDX_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            owner_q  <= '0;
            cnt_q    <= '0;
            op_a_q   <= '0;
            op_b_q   <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
            cnt_q    <= cnt_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            result_q <= result_d;
        end
    end

    assign bus.req_ready  = req_ready;
    assign bus.resp_valid = resp_valid;
    assign bus.resp_sum   = result_q;
    assign bus.add_en     = add_en;
    assign bus.add_in1    = op_a_q;
    assign bus.add_in2    = op_b_q;
    assign bus.busy       = (state_q != IDLE);

endmodule

// File: tb/tb_half_add_arbiter.sv
// Directed bench for half_add_arbiter with a fixed-latency adder model.
module tb_half_add_arbiter;
    import half_pkg::*;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned ADD_LAT = 4;

    logic clk  = 1'b0;
    logic nrst = 1'b0;
    int   tests = 0;
    int   fails = 0;
    int   lat_cnt = 0;

    half_add_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

    half_add_arbiter #(.NUM_REQ(NUM_REQ), .ADD_LAT(ADD_LAT)) dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Adder model: garbage until ADD_LAT cycles after the enable pulse.
    function automatic logic [15:0] fadd(input logic [15:0] x, input logic [15:0] y);
        if ((x == 16'h3C00 && y == 16'h4000) || (x == 16'h4000 && y == 16'h3C00)) return 16'h4200;
        if (x == 16'h3C00 && y == 16'h3C00) return 16'h4000;
        return x ^ y;
    endfunction

    always @(posedge clk) begin
        if (bus.add_en) lat_cnt <= 1;
        else if (lat_cnt > 0 && lat_cnt < ADD_LAT) lat_cnt <= lat_cnt + 1;
    end

    assign bus.add_out = (lat_cnt == ADD_LAT) ? fadd(bus.add_in1, bus.add_in2) : 16'hDEAD;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_op(input int unsigned c, input logic [15:0] a, input logic [15:0] b);
        bus.req_a[16*c +: 16] = a;
        bus.req_b[16*c +: 16] = b;
    endtask

    // Called at a negedge with inputs set; returns at the negedge where resp_valid is seen.
    task automatic do_op(input string tag, input int unsigned owner, input logic [15:0] exp_sum,
                         input int unsigned exp_lat, input int unsigned exp_en, input bit drop,
                         input int unsigned exp_wait);
        int unsigned n = 0, k = 0, en_cnt = 0, rdy_bad = 0, in_bad = 0;
        logic [15:0] a_exp, b_exp;
        #1;
        while (bus.req_ready == '0 && n < 50) begin
            @(negedge clk); #1; n++;
        end
        chk({tag, ":wait"}, n, exp_wait);
        chk({tag, ":grant"}, bus.req_ready, 32'(1) << owner);
        a_exp = bus.req_a[16*owner +: 16];
        b_exp = bus.req_b[16*owner +: 16];
        do begin
            @(negedge clk);
            k++;
            if (drop && k == 1) bus.req_valid[owner] = 1'b0;
            if (bus.add_en) en_cnt++;
            if (bus.req_ready != '0) rdy_bad++;
            if (exp_en != 0 && (bus.add_in1 !== a_exp || bus.add_in2 !== b_exp)) in_bad++;
        end while (bus.resp_valid == '0 && k < 40);
        chk({tag, ":latency"}, k, exp_lat);
        chk({tag, ":add_en_pulses"}, en_cnt, exp_en);
        chk({tag, ":ready_while_busy"}, rdy_bad, 0);
        chk({tag, ":operand_stable"}, in_bad, 0);
        chk({tag, ":resp_valid"}, bus.resp_valid, 32'(1) << owner);
        chk({tag, ":resp_sum"}, bus.resp_sum, exp_sum);
        chk({tag, ":busy"}, bus.busy, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned bad;
        int unsigned bp_lat, bp_en;
        logic [15:0] bp_in1;
`ifdef HALF_ADD_ARB_ZERO_BYPASS_EN
        bp_lat = 1; bp_en = 0; bp_in1 = 16'h3C00;
`else
        bp_lat = ADD_LAT + 2; bp_en = 1; bp_in1 = 16'h0000;
`endif
        bus.req_valid  = '0;
        bus.req_a      = '0;
        bus.req_b      = '0;
        bus.resp_ready = '0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst:req_ready", bus.req_ready, 0);
        chk("rst:resp_valid", bus.resp_valid, 0);
        chk("rst:add_en", bus.add_en, 0);
        chk("rst:busy", bus.busy, 0);
        chk("rst:add_in", {bus.add_in1, bus.add_in2}, 0);
        chk("rst:resp_sum", bus.resp_sum, 0);
        nrst = 1'b1;

        // 1: single client 0, 1.0 + 2.0
        set_op(0, 16'h3C00, 16'h4000);
        bus.resp_ready = 4'hF;
        bus.req_valid  = 4'b0001;
        do_op("t1", 0, 16'h4200, ADD_LAT + 2, 1, 1, 0);
        @(negedge clk);
        chk("t1:idle_busy", bus.busy, 0);
        chk("t1:idle_resp", bus.resp_valid, 0);

        // 2: all clients valid from a fresh pointer, back-to-back
        nrst = 1'b0;
        @(negedge clk);
        nrst = 1'b1;
        set_op(1, 16'h3C00, 16'h3C00);
        set_op(2, 16'h1234, 16'h0F0F);
        set_op(3, 16'hAAAA, 16'h5555);
        bus.req_valid = 4'hF;
        do_op("t2g0", 0, 16'h4200, ADD_LAT + 2, 1, 0, 0);
        @(negedge clk);
        do_op("t2g1", 1, 16'h4000, ADD_LAT + 2, 1, 0, 0);
        @(negedge clk);
        do_op("t2g2", 2, 16'h1D3B, ADD_LAT + 2, 1, 0, 0);
        @(negedge clk);
        do_op("t2g3", 3, 16'hFFFF, ADD_LAT + 2, 1, 0, 0);
        @(negedge clk);
        do_op("t2g0b", 0, 16'h4200, ADD_LAT + 2, 1, 0, 0);
        bus.req_valid = '0;

        // 3: owner 2 back-pressures for 10 cycles; non-owner ready ignored
        @(negedge clk);
        bus.resp_ready = 4'b1011;
        bus.req_valid  = 4'b0100;
        do_op("t3", 2, 16'h1D3B, ADD_LAT + 2, 1, 1, 0);
        bus.req_valid[0] = 1'b1;
        bad = 0;
        repeat (10) begin
            @(negedge clk); #1;
            if (bus.resp_valid !== 4'b0100 || bus.resp_sum !== 16'h1D3B ||
                bus.req_ready !== 4'b0000 || bus.add_en !== 1'b0) bad++;
        end
        chk("t3:hold", bad, 0);
        bus.resp_ready = 4'hF;
        @(negedge clk);
        do_op("t3next", 0, 16'h4200, ADD_LAT + 2, 1, 1, 0);

        // 4: client 3 served, then 0 and 3 compete: pointer wraps to 0
        @(negedge clk);
        bus.req_valid = 4'b1000;
        do_op("t4c3", 3, 16'hFFFF, ADD_LAT + 2, 1, 1, 0);
        bus.req_valid = 4'b1001;
        @(negedge clk);
        do_op("t4c0", 0, 16'h4200, ADD_LAT + 2, 1, 1, 0);
        @(negedge clk);
        do_op("t4c3b", 3, 16'hFFFF, ADD_LAT + 2, 1, 1, 0);

        // 5: reset during WAIT drops the op
        @(negedge clk);
        bus.req_valid = 4'b0010;
        #1;
        chk("t5:grant", bus.req_ready, 4'b0010);
        @(negedge clk);
        bus.req_valid = '0;
        repeat (2) @(negedge clk);
        chk("t5:in_wait", bus.busy, 1);
        nrst = 1'b0;
        #1;
        chk("t5:rst_busy", bus.busy, 0);
        chk("t5:rst_add_en", bus.add_en, 0);
        chk("t5:rst_add_in", {bus.add_in1, bus.add_in2}, 0);
        @(negedge clk);
        chk("t5:rst_resp_valid", bus.resp_valid, 0);
        chk("t5:rst_resp_sum", bus.resp_sum, 0);
        nrst = 1'b1;
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.resp_valid !== '0 || bus.add_en !== 1'b0 || bus.busy !== 1'b0) bad++;
        end
        chk("t5:no_resp", bad, 0);
        bus.req_valid = 4'b0010;
        do_op("t5post", 1, 16'h4000, ADD_LAT + 2, 1, 1, 0);

        // 6: zero operands (bypass when enabled, adder path otherwise)
        @(negedge clk);
        set_op(2, 16'h0000, 16'h3C00);
        bus.req_valid = 4'b0100;
        do_op("t6a", 2, 16'h3C00, bp_lat, bp_en, 1, 0);
        chk("t6a:add_in1", bus.add_in1, bp_in1);
        @(negedge clk);
        set_op(3, 16'h4000, 16'h0000);
        bus.req_valid = 4'b1000;
        do_op("t6b", 3, 16'h4000, bp_lat, bp_en, 1, 0);
        @(negedge clk);
        chk("t6:idle_busy", bus.busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
